// File: rtl/bitwise_ctrl_pkg.sv
// Shared types for the bitwise operator arbiter: opcodes, FSM states, widths.
package bitwise_ctrl_pkg;

  localparam int unsigned OP_W          = 2;
  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [OP_W-1:0] {
    OP_OR    = 2'd0,
    OP_AND   = 2'd1,
    OP_NOT_A = 2'd2,
    OP_XOR   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/bitwise_unit.sv
// Combinational bitwise operator: y = f(a, b, op), all operations at WIDTH bits.
// Optional feature macro: BITWISE_XOR_EN (op 3 = A^B; otherwise op 3 is illegal).
// Ports:
//   a, b  in   WIDTH  operands
//   op    in   2      opcode (op_e)
//   y     out  WIDTH  result (0 when err)
//   err   out  1      opcode illegal in this build
module bitwise_unit
  import bitwise_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  // Opcode decode; illegal opcodes return zero with err set.
  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op_e'(op))
      OP_OR:    y = a | b;
      OP_AND:   y = a & b;
      OP_NOT_A: y = ~a;
      OP_XOR: begin
`ifdef BITWISE_XOR_EN
        y = a ^ b;
`else
        err = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/bitwise_op_arbiter.sv
// Two-requester round-robin front end for a shared bitwise operator unit.
// Accepts one operation at a time (IDLE -> EXEC -> HOLD -> IDLE) and returns a
// registered result tagged with the issuing requester.
// Optional feature macro: BITWISE_XOR_EN (passed through to bitwise_unit).
// Ports:
//   clk, reset                 clock, async active-high reset
//   reqN_valid/ready           request handshake (ready is combinational, IDLE only)
//   reqN_a, reqN_b, reqN_op    request operands and opcode
//   res_valid/ready            result handshake
//   res_data, res_id, res_err  registered result, issuing requester, illegal-op flag
module bitwise_op_arbiter
  import bitwise_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             res_err
);

  state_e           r_state;
  logic             r_last_grant;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic             r_id;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_id;
  logic             r_res_err;

  logic             w_any_valid;
  logic             w_grant_id;
  logic             w_accept;
  logic [WIDTH-1:0] w_y;
  logic             w_err;

  // Round robin: on a tie the requester that did not win last time is granted.
  assign w_any_valid = req0_valid | req1_valid;
  assign w_grant_id  = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;

  // Ready is masked by reset so no accept pulse can escape while reset is held.
  assign w_accept   = (r_state == S_IDLE) & w_any_valid & ~reset;
  assign req0_ready = w_accept & ~w_grant_id;
  assign req1_ready = w_accept &  w_grant_id;

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign res_err   = r_res_err;

  bitwise_unit #(
    .WIDTH (WIDTH)
  ) u_unit (
    .a   (r_a),
    .b   (r_b),
    .op  (r_op),
    .y   (w_y),
    .err (w_err)
  );

  // Control FSM with operand latch and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_id         <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_id     <= 1'b0;
      r_res_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a          <= w_grant_id ? req1_a  : req0_a;
            r_b          <= w_grant_id ? req1_b  : req0_b;
            r_op         <= w_grant_id ? req1_op : req0_op;
            r_id         <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_res_data  <= w_y;
          r_res_id    <= r_id;
          r_res_err   <= w_err;
          r_res_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          if (r_res_valid & res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitwise_op_arbiter.sv
// Directed bench for bitwise_op_arbiter (WIDTH=4). Inputs change 1 ns after
// the rising edge, outputs are sampled 1 ns after that.
module tb_bitwise_op_arbiter;

  logic       clk;
  logic       reset;
  logic       req0_valid, req0_ready;
  logic [3:0] req0_a, req0_b;
  logic [1:0] req0_op;
  logic       req1_valid, req1_ready;
  logic [3:0] req1_a, req1_b;
  logic [1:0] req1_op;
  logic       res_valid, res_ready;
  logic [3:0] res_data;
  logic       res_id, res_err;

  int n_checks = 0;
  int n_errors = 0;

  bitwise_op_arbiter #(.WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
    .res_err    (res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called 1 ns after inputs were driven, with the DUT in IDLE.
  // Checks grant, EXEC latency, result contents, then completes the result handshake.
  task automatic do_txn(input string tag, input logic exp_id, input logic [3:0] exp_data,
                        input logic exp_err, input bit drop);
    #1;
    check({tag, "_rdy0"}, 32'(req0_ready), 32'(!exp_id));
    check({tag, "_rdy1"}, 32'(req1_ready), 32'(exp_id));
    @(posedge clk); #1;
    if (drop) begin
      if (exp_id) req1_valid = 1'b0;
      else        req0_valid = 1'b0;
    end
    #1;
    check({tag, "_exec_vld"}, 32'(res_valid), 32'd0);
    check({tag, "_exec_rdy"}, 32'(req0_ready | req1_ready), 32'd0);
    @(posedge clk); #1;
    check({tag, "_vld"},  32'(res_valid), 32'd1);
    check({tag, "_data"}, 32'(res_data),  32'(exp_data));
    check({tag, "_id"},   32'(res_id),    32'(exp_id));
    check({tag, "_err"},  32'(res_err),   32'(exp_err));
    res_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_done"}, 32'(res_valid), 32'd0);
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] xor_data;
    logic       xor_err;
`ifdef BITWISE_XOR_EN
    xor_data = 4'b0110;
    xor_err  = 1'b0;
`else
    xor_data = 4'b0000;
    xor_err  = 1'b1;
`endif

    reset = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    res_ready = 1'b0;

    // Reset state, including ready masked while reset is held.
    @(posedge clk); @(posedge clk); #1;
    req0_valid = 1'b1;
    #1;
    check("rst_vld",  32'(res_valid),  32'd0);
    check("rst_data", 32'(res_data),   32'd0);
    check("rst_id",   32'(res_id),     32'd0);
    check("rst_err",  32'(res_err),    32'd0);
    check("rst_rdy0", 32'(req0_ready), 32'd0);
    check("rst_rdy1", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: req0 only, OR.
    req0_valid = 1'b1; req0_a = 4'b1010; req0_b = 4'b0101; req0_op = 2'd0;
    do_txn("t1", 1'b0, 4'b1111, 1'b0, 1'b1);

    // 2: tie right after reset, req0 first then req1.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    req0_valid = 1'b1; req0_a = 4'b1111; req0_b = 4'b0011; req0_op = 2'd1;
    req1_valid = 1'b1; req1_a = 4'b0001; req1_b = 4'b0000; req1_op = 2'd2;
    do_txn("t2a", 1'b0, 4'b0011, 1'b0, 1'b1);
    do_txn("t2b", 1'b1, 4'b1110, 1'b0, 1'b1);

    // 3: both held valid continuously, grants alternate.
    req0_valid = 1'b1; req0_a = 4'b0011; req0_b = 4'b0100; req0_op = 2'd0;
    req1_valid = 1'b1; req1_a = 4'b0110; req1_b = 4'b1100; req1_op = 2'd1;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 1) do_txn($sformatf("t3_%0d", i), 1'b1, 4'b0100, 1'b0, 1'b0);
      else            do_txn($sformatf("t3_%0d", i), 1'b0, 4'b0111, 1'b0, 1'b0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // 4: result stalled 5 cycles in HOLD with a pending request.
    req1_valid = 1'b1; req1_a = 4'b0001; req1_b = 4'b0010; req1_op = 2'd0;
    #1;
    check("t4_rdy1", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 4'b0101; req0_b = 4'b0011; req0_op = 2'd1;
    #1;
    check("t4_exec_rdy0", 32'(req0_ready), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4_hold_vld%0d", i),  32'(res_valid), 32'd1);
      check($sformatf("t4_hold_data%0d", i), 32'(res_data),  32'h3);
      check($sformatf("t4_hold_id%0d", i),   32'(res_id),    32'd1);
      check($sformatf("t4_hold_rdy%0d", i),  32'(req0_ready | req1_ready), 32'd0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    #1;
    check("t4_hs_rdy0", 32'(req0_ready), 32'd0);
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("t4_hs_vld", 32'(res_valid), 32'd0);
    do_txn("t4_next", 1'b0, 4'b0001, 1'b0, 1'b1);

    // 5: op 3, build dependent.
    req0_valid = 1'b1; req0_a = 4'b1100; req0_b = 4'b1010; req0_op = 2'd3;
    do_txn("t5_op3", 1'b0, xor_data, xor_err, 1'b1);

    // NOT-A ignores B and stays within WIDTH.
    req1_valid = 1'b1; req1_a = 4'b0101; req1_b = 4'b1111; req1_op = 2'd2;
    do_txn("t5_nota", 1'b1, 4'b1010, 1'b0, 1'b1);

    // 6: reset during EXEC; last grant was req0, so only a reset last_grant lets req0 win the tie.
    req0_valid = 1'b1; req0_a = 4'b1111; req0_b = 4'b1111; req0_op = 2'd0;
    #1;
    check("t6_rdy0", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 4'b1000; req0_b = 4'b0001; req0_op = 2'd0;
    req1_valid = 1'b1; req1_a = 4'b1111; req1_b = 4'b0110; req1_op = 2'd1;
    reset = 1'b1;
    #1;
    check("t6_rst_vld",  32'(res_valid),  32'd0);
    check("t6_rst_data", 32'(res_data),   32'd0);
    check("t6_rst_id",   32'(res_id),     32'd0);
    check("t6_rst_err",  32'(res_err),    32'd0);
    check("t6_rst_rdy",  32'(req0_ready | req1_ready), 32'd0);
    @(posedge clk); #1;
    check("t6_rst_vld2", 32'(res_valid), 32'd0);
    reset = 1'b0;
    do_txn("t6a", 1'b0, 4'b1001, 1'b0, 1'b1);
    do_txn("t6b", 1'b1, 4'b0110, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
